// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the cache and buffers {pc, inst} in a small FIFO for decode.
// Optional FETCH_PERF_EN adds stall/flush performance counters.
module fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_inst_i,
    input  logic              halt_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              misalign_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          mis_q, mis_d;
    logic [31:0]   hold_inst_q, hold_pc_q;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic          pop, push, full;

    assign full = (cnt_q == CW'(DEPTH));
    assign pop  = valid_o & ready_i;
    assign push = !halt_i & !redirect_i & (!full | pop);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        mis_d = 1'b0;
        if (redirect_i) begin
            pc_d  = {redirect_pc_i[31:2], 2'b00};
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            mis_d = |redirect_pc_i[1:0];
        end else begin
            if (push) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + PW'(1);
            end
            if (pop)
                rd_d = rd_q + PW'(1);
            if (push && !pop)
                cnt_d = cnt_q + CW'(1);
            else if (pop && !push)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            mis_q       <= 1'b0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            mis_q <= mis_d;
            // Shadow of the head so outputs keep their last value once the FIFO drains.
            if (valid_o) begin
                hold_inst_q <= fifo_inst_q[rd_q];
                hold_pc_q   <= fifo_pc_q[rd_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_inst_q[wr_q] <= imem_inst_i;
            fifo_pc_q[wr_q]   <= pc_q;
        end
    end

    assign imem_addr_o = pc_q[ADDR_W+1:2];
    assign valid_o     = (cnt_q != '0);
    assign inst_o      = valid_o ? fifo_inst_q[rd_q] : hold_inst_q;
    assign pc_o        = valid_o ? fifo_pc_q[rd_q]   : hold_pc_q;
    assign pc_plus4_o  = pc_o + 32'd4;
    assign misalign_o  = mis_q;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (full && !pop && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_i && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-level model of the fetch stream, random stimulus, negedge monitor.
module tb_fetch_unit;
    localparam int          ADDR_W   = 6;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_i, halt_i, redirect_i, ready_i;
    logic [31:0]       redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_inst_i, inst_o, pc_o, pc_plus4_o;
    logic              valid_o, misalign_o;
`ifdef FETCH_PERF_EN
    logic [31:0]       stall_cnt_o;
    logic [15:0]       flush_cnt_o;
`endif

    logic [31:0] mem [2**ADDR_W];
    assign imem_inst_i = mem[imem_addr_o];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_addr_o  (imem_addr_o),
        .imem_inst_i  (imem_inst_i),
        .halt_i       (halt_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .misalign_o   (misalign_o)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    // Model state: the instructions owed to decode, the next fetch PC and the misalign flag.
    ent_t        sb[$];
    logic [31:0] m_pc  = RESET_PC;
    logic        m_mis = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_mis = 1'b0;
    bit          armed = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input bit r, input bit h, input bit d, input logic [31:0] t, input bit rd);
        int   n;
        bit   pop, push;
        ent_t e;
        @(posedge clk); #1;
        rst_i = r; halt_i = h; redirect_i = d; redirect_pc_i = t; ready_i = rd;
        n = sb.size();
        exp_valid = (n > 0);
        exp_pc    = m_pc;
        exp_mis   = m_mis;
        if (r) begin
            sb.delete();
            m_pc  = RESET_PC;
            m_mis = 1'b0;
        end else if (d) begin
            sb.delete();
            m_pc  = {t[31:2], 2'b00};
            m_mis = (t[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            pop   = (n > 0) && rd;
            push  = !h && ((n < DEPTH) || pop);
            if (push) begin
                e.pc   = m_pc;
                e.inst = mem[m_pc[ADDR_W+1:2]];
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Monitor: compares the presented head against the oldest owed instruction.
    initial begin
        ent_t e;
        logic [31:0] exp_addr;
        forever begin
            @(negedge clk);
            if (armed) begin
                exp_addr = {{(32-ADDR_W){1'b0}}, exp_pc[ADDR_W+1:2]};
                chk("valid", {31'd0, valid_o}, {31'd0, exp_valid});
                chk("imem_addr", {{(32-ADDR_W){1'b0}}, imem_addr_o}, exp_addr);
                chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
                if (valid_o && exp_valid && sb.size() > 0) begin
                    e = sb[0];
                    chk("pc", pc_o, e.pc);
                    chk("inst", inst_o, e.inst);
                    chk("pc_plus4", pc_plus4_o, e.pc + 32'd4);
                    if (ready_i && !rst_i && !redirect_i) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2**ADDR_W; k++) mem[k] = 32'hA000_0000 + k;
        rst_i = 1'b1; halt_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc_plus4", pc_plus4_o, 32'd4);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt_o}, 32'd0);
`endif
        armed = 1'b1;

        repeat (10) cycle(0, 0, 0, 0, 1);                 // free run
        repeat (5)  cycle(0, 0, 0, 0, 0);                 // back-pressure to full
        repeat (4)  cycle(0, 0, 0, 0, 1);
        repeat (3)  cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0042, 1);                 // misaligned redirect while full
        repeat (4)  cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'h0000_00F0, 1);                 // run across cache-address wrap
        repeat (14) cycle(0, 0, 0, 0, 1);
        repeat (3)  cycle(0, 0, 0, 0, 0);
        repeat (3)  cycle(0, 1, 0, 0, 1);                 // halt drains buffered entries
        repeat (4)  cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'hFFFF_FFF4, 1);                 // 32-bit PC wrap
        repeat (6)  cycle(0, 0, 0, 0, 1);
        repeat (3)  cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h0000_0042, 1);                 // reset beats redirect mid-stream
        repeat (5)  cycle(0, 0, 0, 0, 1);

        for (int i = 0; i < 2500; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 6, t, $urandom_range(0, 99) < 70);
        end
        repeat (2) cycle(0, 0, 0, 0, 1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction cache.
- Owns the program counter and drives the word address into the cache.
- Captures the combinational instruction word and its PC into a small FIFO.
- Presents the FIFO head to the decode stage with a valid/ready handshake; handles stall, halt and branch/jump redirect with flush.

Parameters:
- ADDR_W, 6: cache word-address width; cache depth is 2^ADDR_W words.
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- DEPTH, 2: fetch FIFO entries; legal values 2 or 4.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_addr_o  out  ADDR_W  word address to the instruction cache = pc[ADDR_W+1:2].
- imem_inst_i  in  32  instruction word returned combinationally by the cache for imem_addr_o.
- halt_i  in  1  when 1, no new fetches; FIFO keeps draining.
- redirect_i  in  1  branch/jump taken; flush and reload the PC.
- redirect_pc_i  in  32  byte target address, sampled when redirect_i=1.
- valid_o  out  1  FIFO head holds a valid instruction.
- ready_i  in  1  decode accepts the head this cycle.
- inst_o  out  32  instruction at the FIFO head.
- pc_o  out  32  byte PC of inst_o.
- pc_plus4_o  out  32  pc_o + 4, wrapping modulo 2^32.
- misalign_o  out  1  one-cycle pulse: the last accepted redirect target had bits [1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: pc = RESET_PC; FIFO count = 0; valid_o = 0; inst_o = 0; pc_o = 0; pc_plus4_o = 4; misalign_o = 0. Reset overrides every other input in the same cycle, including a reset asserted mid-stream: FIFO contents are discarded.
- imem_addr_o is purely combinational from the pc register.
- Fetch timing: imem_inst_i is sampled in the same cycle its address is presented, so fetch latency is one cycle.
  - An instruction fetched in cycle N appears on valid_o / inst_o in cycle N+1.
- pop = valid_o & ready_i.
- push = !halt_i & !redirect_i & (count < DEPTH | pop).
  - A full FIFO with a simultaneous pop still pushes.
- On push: write {pc, imem_inst_i} at the tail; pc <= pc + 4.
- When push = 0: pc holds.
- count update:
  - push & !pop: count + 1
  - pop & !push: count - 1
  - both or neither: count unchanged
- Outputs come from registered FIFO storage only; there is no combinational path from imem_inst_i to inst_o.
- Redirect (highest priority after reset):
  - count <= 0; pc <= {redirect_pc_i[31:2], 2'b00}.
  - No push, and any pop that cycle is discarded.
  - valid_o is 0 in the next cycle.
  - The target instruction is valid two cycles after redirect_i was sampled.
  - misalign_o <= (redirect_pc_i[1:0] != 0) for exactly one cycle; otherwise misalign_o <= 0.
- Wrap-around:
  - pc is a full 32-bit counter and wraps 32'hFFFF_FFFC -> 0.
  - imem_addr_o wraps modulo 2^ADDR_W words; for ADDR_W=6, byte 0x100 fetches word 0.
- Halt:
  - While halt_i = 1, pc holds and nothing is pushed; buffered entries still drain.
  - Deasserting halt_i resumes fetch from the held pc.
- Empty FIFO:
  - valid_o = 0; inst_o, pc_o and pc_plus4_o hold their last values (don't-care to decode).
  - ready_i is ignored.
- Ordering: instructions leave in strictly increasing pc order (mod 2^32) between redirects; there are no duplicates or skips.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt_o [31:0]: counts cycles where push = 0 because count == DEPTH and !pop.
  - flush_cnt_o [15:0]: counts accepted redirects.
- Both counters reset to 0 on rst_i, saturate at all-ones, and count nothing during reset.
- When not defined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then free-run, ready_i=1, cache word k = 32'hA000_0000+k -> valid_o first high 1 cycle after reset release; pc_o = 0, 4, 8, ...; inst_o = A0000000, A0000001, ... one per cycle.
- ready_i=0 for 5 cycles from reset (DEPTH=2) -> count reaches 2, pc stops at 8, imem_addr_o=2; on ready_i=1 the outputs are pc 0 then 4, then 8 with no gap or duplicate.
- redirect_i=1, redirect_pc_i=32'h0000_0042 while FIFO full -> next cycle valid_o=0, misalign_o=1, imem_addr_o=16; following cycle pc_o=0x40, pc_plus4_o=0x44.
- Fetch past word 63 with ADDR_W=6 -> pc_o=0x100 carries cache word 0's data; imem_addr_o=0.
- halt_i=1 for 3 cycles with 2 entries buffered, ready_i=1 -> 2 entries drain, then valid_o=0, pc held; on halt_i=0 fetch resumes at the held pc.
- rst_i asserted for 1 cycle mid-stream with FIFO full and redirect_i=1 simultaneously -> next cycle valid_o=0, pc=RESET_PC, misalign_o=0; with FETCH_PERF_EN, both counters read 0.
